// File: rtl/rs_encoder_255.sv
// rtl/rs_encoder_255.sv - systematic RS(255,K) encoder over GF(2^8), poly 0x11D
//
// Purpose:
//   Builds g(x) = prod_{i=0..NPAR-1}(x + alpha^i) after reset, then passes
//   KMSG message symbols straight through and appends NPAR parity symbols
//   computed by a GF(2^8) division LFSR.
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   data_in[7:0]   in   message symbol, highest-degree symbol first
//   data_valid     in   data_in valid this cycle
//   in_ready       out  symbol is accepted when data_valid & in_ready
//   code_out[7:0]  out  registered codeword symbol
//   code_valid     out  code_out valid (no backpressure)
//   code_is_parity out  code_out is a parity symbol
//   code_last      out  final parity symbol of the codeword
//   gen_done       out  generator coefficients ready (sticky until reset)

module rs_encoder_255 #(
   parameter int NPAR = 16,
   parameter int KMSG = 239
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       in_ready,
   output logic [7:0] code_out,
   output logic       code_valid,
   output logic       code_is_parity,
   output logic       code_last,
   output logic       gen_done
);

   typedef enum logic [1:0] {S_GEN, S_IDLE, S_DATA, S_PAR} state_t;

   state_t     r_state;
   logic [7:0] r_g   [0:NPAR];
   logic [7:0] r_par [0:NPAR-1];
   logic [7:0] r_root;
   logic [7:0] r_cnt;

   logic [7:0] w_fb;
   logic [7:0] w_mul_a;
   logic [7:0] w_prod [0:NPAR-1];
   logic       w_xfer;

   // Shift-and-add multiply reduced modulo x^8+x^4+x^3+x^2+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
      end
      return p;
   endfunction

   assign in_ready = (r_state == S_IDLE) || (r_state == S_DATA);
   assign w_xfer   = in_ready && data_valid;
   assign w_fb     = data_in ^ r_par[NPAR-1];

   // One bank of multipliers against g[0..NPAR-1]: the root during GEN, the
   // LFSR feedback otherwise. g[NPAR] is still zero on every GEN step where it
   // would be multiplied, so it never needs a multiplier.
   assign w_mul_a = (r_state == S_GEN) ? r_root : w_fb;

   for (genvar j = 0; j < NPAR; j++) begin : g_mul
      assign w_prod[j] = gf_mul(w_mul_a, r_g[j]);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state        <= S_GEN;
         r_root         <= 8'h01;
         r_cnt          <= 8'h00;
         code_out       <= 8'h00;
         code_valid     <= 1'b0;
         code_is_parity <= 1'b0;
         code_last      <= 1'b0;
         gen_done       <= 1'b0;
         for (int j = 0; j <= NPAR; j++) r_g[j] <= (j == 0) ? 8'h01 : 8'h00;
         for (int j = 0; j < NPAR; j++)  r_par[j] <= 8'h00;
      end else begin
         code_valid     <= 1'b0;
         code_is_parity <= 1'b0;
         code_last      <= 1'b0;
         case (r_state)
            S_GEN: begin
               // Multiply the running product by (x + root).
               r_g[0] <= w_prod[0];
               for (int j = 1; j < NPAR; j++) r_g[j] <= r_g[j-1] ^ w_prod[j];
               r_g[NPAR] <= r_g[NPAR-1];
               r_root    <= gf_mul(r_root, 8'h02);
               if (r_cnt == 8'(NPAR - 1)) begin
                  r_cnt    <= 8'h00;
                  r_state  <= S_IDLE;
                  gen_done <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 8'h01;
               end
            end
            S_IDLE, S_DATA: begin
               if (w_xfer) begin
                  r_par[0] <= w_prod[0];
                  for (int j = 1; j < NPAR; j++) r_par[j] <= r_par[j-1] ^ w_prod[j];
                  code_out   <= data_in;
                  code_valid <= 1'b1;
                  if (r_cnt == 8'(KMSG - 1)) begin
                     r_cnt   <= 8'h00;
                     r_state <= S_PAR;
                  end else begin
                     r_cnt   <= r_cnt + 8'h01;
                     r_state <= S_DATA;
                  end
               end
            end
            S_PAR: begin
               // Shifting zeros in leaves the LFSR clear for the next codeword.
               code_out       <= r_par[NPAR-1];
               code_valid     <= 1'b1;
               code_is_parity <= 1'b1;
               r_par[0]       <= 8'h00;
               for (int j = 1; j < NPAR; j++) r_par[j] <= r_par[j-1];
               if (r_cnt == 8'(NPAR - 1)) begin
                  code_last <= 1'b1;
                  r_cnt     <= 8'h00;
                  r_state   <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 8'h01;
               end
            end
            default: r_state <= S_GEN;
         endcase
      end
   end

endmodule

// File: tb/tb_rs_encoder_255.sv
// tb/tb_rs_encoder_255.sv - self-checking bench for rs_encoder_255 (NPAR=2 and NPAR=16)

module tb_rs_encoder_255;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [7:0] d2_in,  d16_in;
   logic       d2_v,   d16_v;
   logic       d2_rdy, d16_rdy;
   logic [7:0] d2_out, d16_out;
   logic       d2_cv,  d16_cv;
   logic       d2_par, d16_par;
   logic       d2_last, d16_last;
   logic       d2_gen, d16_gen;

   rs_encoder_255 #(.NPAR(2), .KMSG(253)) u_d2 (
      .clock(clk), .reset(rst_n), .data_in(d2_in), .data_valid(d2_v),
      .in_ready(d2_rdy), .code_out(d2_out), .code_valid(d2_cv),
      .code_is_parity(d2_par), .code_last(d2_last), .gen_done(d2_gen)
   );

   rs_encoder_255 u_d16 (
      .clock(clk), .reset(rst_n), .data_in(d16_in), .data_valid(d16_v),
      .in_ready(d16_rdy), .code_out(d16_out), .code_valid(d16_cv),
      .code_is_parity(d16_par), .code_last(d16_last), .gen_done(d16_gen)
   );

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] p1;
      logic [7:0] p0;
   } vec_t;

   vec_t       tbl [7];
   logic [9:0] q2  [$];
   logic [9:0] q16 [$];
   logic [7:0] msg [0:511];
   logic [7:0] gold [16];
   logic [7:0] par_b [16];
   int         lo16;
   int         total = 0;
   int         bad = 0;
   int         n2, n16;

   // Captured words are {last, parity, symbol}.
   always @(negedge clk) begin
      if (d2_cv)  q2.push_back({d2_last, d2_par, d2_out});
      if (d16_cv) q16.push_back({d16_last, d16_par, d16_out});
      if (d16_gen && !d16_rdy) lo16 = lo16 + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, want finish before 2ms");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   // Reference GF(2^8) multiply, MSB-first Horner form.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1D : 8'h00);
         if (b[i]) p = p ^ a;
      end
      return p;
   endfunction

   // Bit i set when syndrome C(alpha^i) of the NPAR=16 codeword at base is nonzero.
   function automatic int syn_mask(input int base);
      int         m;
      logic [7:0] a;
      logic [7:0] s;
      m = 0;
      a = 8'h01;
      if (base + 255 > q16.size()) return -1;
      for (int i = 0; i < 16; i++) begin
         s = 8'h00;
         for (int k = 0; k < 255; k++) s = gmul(s, a) ^ q16[base+k][7:0];
         if (s != 8'h00) m = m | (1 << i);
         a = gmul(a, 8'h02);
      end
      return m;
   endfunction

   // Errors in an NPAR=16 codeword: echoed data and parity/last flags.
   function automatic int frame_err(input int qbase, input int mbase);
      int e;
      e = 0;
      if (qbase + 255 > q16.size()) return 999;
      for (int k = 0; k < 239; k++)
         if (q16[qbase+k] !== {2'b00, msg[mbase+k]}) e++;
      for (int k = 0; k < 16; k++)
         if (q16[qbase+239+k][9:8] !== {(k == 15), 1'b1}) e++;
      return e;
   endfunction

   function automatic int echo2_err();
      int e;
      e = 0;
      if (q2.size() < 253) return 999;
      for (int k = 0; k < 253; k++)
         if (q2[k] !== {2'b00, msg[k]}) e++;
      return e;
   endfunction

   function automatic int par_diff(input int qbase, input logic [7:0] exp_p [16]);
      int e;
      e = 0;
      if (qbase + 16 > q16.size()) return 999;
      for (int k = 0; k < 16; k++)
         if (q16[qbase+k][7:0] !== exp_p[k]) e++;
      return e;
   endfunction

   // Presents msg[start..start+n-1]; returns once n transfers have happened.
   // data_valid is left as-is so a following call continues without a gap.
   task automatic drive(input bit wide, input int start, input int n, input bit gaps);
      int i;
      int guard;
      bit v;
      bit xfer;
      i = 0;
      guard = 0;
      while (i < n && guard < 4000) begin
         v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (wide) begin
            d16_in = msg[start+i];
            d16_v  = v;
         end else begin
            d2_in = msg[start+i];
            d2_v  = v;
         end
         @(negedge clk);
         xfer = v && (wide ? d16_rdy : d2_rdy);
         @(posedge clk);
         #1;
         if (xfer) i++;
         guard++;
      end
      if (i < n) check("drive_timeout", i, n);
   endtask

   task automatic wait_count(input bit wide, input int n);
      int guard;
      guard = 0;
      while (((wide ? q16.size() : q2.size()) < n) && guard < 2000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if ((wide ? q16.size() : q2.size()) < n)
         check("wait_timeout", wide ? q16.size() : q2.size(), n);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic count_gen();
      n2 = -1;
      n16 = -1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (d2_gen && n2 < 0) n2 = c;
         if (d16_gen && n16 < 0) n16 = c;
      end
   endtask

   initial begin
      tbl[0] = '{a:8'h00, b:8'h01, p1:8'h03, p0:8'h02};
      tbl[1] = '{a:8'h00, b:8'h02, p1:8'h06, p0:8'h04};
      tbl[2] = '{a:8'h00, b:8'h80, p1:8'h9D, p0:8'h1D};
      tbl[3] = '{a:8'h01, b:8'h00, p1:8'h07, p0:8'h06};
      tbl[4] = '{a:8'h01, b:8'h01, p1:8'h04, p0:8'h04};
      tbl[5] = '{a:8'h02, b:8'h00, p1:8'h0E, p0:8'h0C};
      tbl[6] = '{a:8'h00, b:8'h00, p1:8'h00, p0:8'h00};

      rst_n = 1'b0;
      d2_in = 8'h00; d2_v = 1'b0; d16_in = 8'h00; d16_v = 1'b0;
      lo16 = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outs_p2",  int'({d2_rdy, d2_cv, d2_par, d2_last, d2_gen, d2_out}), 0);
      check("rst_outs_p16", int'({d16_rdy, d16_cv, d16_par, d16_last, d16_gen, d16_out}), 0);

      rst_n = 1'b1;
      count_gen();
      check("gen_cycles_p2", n2, 2);
      check("gen_cycles_p16", n16, 16);
      check("ready_after_gen", int'({d2_rdy, d16_rdy}), 3);

      // NPAR=2: 251 zeros, a, b; parity hand-computed against g(x)=x^2+3x+2.
      for (int t = 0; t < 7; t++) begin
         for (int k = 0; k < 251; k++) msg[k] = 8'h00;
         msg[251] = tbl[t].a;
         msg[252] = tbl[t].b;
         q2.delete();
         drive(1'b0, 0, 253, t[0]);
         d2_v = 1'b0;
         wait_count(1'b0, 255);
         check($sformatf("p2_size_%0d", t), q2.size(), 255);
         check($sformatf("p2_echo_%0d", t), echo2_err(), 0);
         check($sformatf("p2_par1_%0d", t), int'(q2.size() > 253 ? q2[253][7:0] : 8'hxx), int'(tbl[t].p1));
         check($sformatf("p2_par0_%0d", t), int'(q2.size() > 254 ? q2[254][7:0] : 8'hxx), int'(tbl[t].p0));
         check($sformatf("p2_flags_%0d", t),
               int'(q2.size() > 254 ? {q2[253][9:8], q2[254][9:8]} : 4'h0), 7);
      end

      // NPAR=16 all-zero message.
      for (int k = 0; k < 239; k++) msg[k] = 8'h00;
      q16.delete();
      drive(1'b1, 0, 239, 1'b0);
      d16_v = 1'b0;
      wait_count(1'b1, 255);
      check("zero_size", q16.size(), 255);
      check("zero_frame", frame_err(0, 0), 0);
      begin
         int nz;
         int nl;
         nz = 0;
         nl = 0;
         foreach (q16[k]) begin
            if (q16[k][7:0] != 8'h00) nz++;
            if (q16[k][9]) nl++;
         end
         check("zero_parity_nonzero", nz, 0);
         check("zero_last_count", nl, 1);
      end

      // NPAR=16 random message with valid gaps.
      for (int k = 0; k < 239; k++) msg[k] = 8'($urandom_range(0, 255));
      q16.delete();
      lo16 = 0;
      drive(1'b1, 0, 239, 1'b1);
      d16_v = 1'b0;
      wait_count(1'b1, 255);
      check("rand_size", q16.size(), 255);
      check("rand_frame", frame_err(0, 0), 0);
      check("rand_syndromes", syn_mask(0), 0);
      check("rand_ready_low", lo16, 16);
      for (int k = 0; k < 16; k++) gold[k] = (q16.size() > 239 + k) ? q16[239+k][7:0] : 8'h00;

      // Reset after 100 accepted symbols.
      q16.delete();
      drive(1'b1, 0, 100, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst_outs", int'({d16_rdy, d16_cv, d16_par, d16_last, d16_gen, d16_out}), 0);
      d16_v = 1'b0;
      @(posedge clk);
      #1;
      q16.delete();
      rst_n = 1'b1;
      count_gen();
      check("midrst_gen_cycles", n16, 16);
      check("midrst_no_partial", q16.size(), 0);
      drive(1'b1, 0, 239, 1'b0);
      d16_v = 1'b0;
      wait_count(1'b1, 255);
      check("midrst_frame", frame_err(0, 0), 0);
      check("midrst_vs_golden", par_diff(239, gold), 0);

      // Back-to-back codewords with data_valid held high throughout.
      for (int k = 239; k < 478; k++) msg[k] = 8'($urandom_range(0, 255));
      q16.delete();
      lo16 = 0;
      drive(1'b1, 0, 478, 1'b0);
      d16_v = 1'b0;
      wait_count(1'b1, 510);
      check("b2b_size", q16.size(), 510);
      check("b2b_frame_a", frame_err(0, 0), 0);
      check("b2b_frame_b", frame_err(255, 239), 0);
      check("b2b_parity_a", par_diff(239, gold), 0);
      check("b2b_syndromes_b", syn_mask(255), 0);
      check("b2b_ready_low", lo16, 32);
      for (int k = 0; k < 16; k++) par_b[k] = (q16.size() > 494 + k) ? q16[494+k][7:0] : 8'h00;

      q16.delete();
      drive(1'b1, 239, 239, 1'b0);
      d16_v = 1'b0;
      wait_count(1'b1, 255);
      check("solo_b_frame", frame_err(0, 239), 0);
      check("solo_b_vs_b2b", par_diff(239, par_b), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
